// File: rtl/span_sequencer.sv
// Span sequencer: walks one 8-pixel tile row across 2 or 3 line-buffer words,
// issuing a read beat and a merge beat per word and clipping off-line writes.
module span_sequencer #(
  parameter int unsigned LINE_WORDS = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        span_valid,
  output logic        span_ready,
  input  logic [8:0]  span_x,
  input  logic [1:0]  span_z,
  input  logic [3:0]  span_palette,
  input  logic [31:0] span_data,
  output logic        span_done,
  output logic [6:0]  lb_addr,
  output logic        lb_rd,
  output logic        lb_we,
  output logic        cmb_first,
  output logic [1:0]  cmb_offset,
  output logic [1:0]  cmb_z,
  output logic [3:0]  cmb_palette,
  output logic [31:0] cmb_tile,
  output logic [11:0] cmb_previous,
  input  logic [11:0] cmb_previous_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, MERGE = 2'd2} state_t;

  state_t      state, state_nx;
  logic [1:0]  beat, beat_nx;
  logic [7:0]  word, word_nx;
  logic [1:0]  off, off_nx;
  logic [1:0]  z, z_nx;
  logic [3:0]  pal, pal_nx;
  logic [31:0] data, data_nx;
  logic [11:0] carry, carry_nx;
  logic        last;

  logic        ready_nx, done_nx, rd_nx, we_nx, first_nx;
  logic [6:0]  addr_nx;
  logic [1:0]  offset_nx, cz_nx;
  logic [3:0]  cpal_nx;
  logic [31:0] tile_nx;
  logic [11:0] prev_nx;

  // Next state, plus the output values that state will present (outputs are registered).
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    word_nx  = word;
    off_nx   = off;
    z_nx     = z;
    pal_nx   = pal;
    data_nx  = data;
    carry_nx = carry;
    last     = (beat == ((off == 2'd0) ? 2'd1 : 2'd2));

    case (state)
      IDLE: begin
        if (span_valid && span_ready) begin
          off_nx   = span_x[1:0];
          z_nx     = span_z;
          pal_nx   = span_palette;
          data_nx  = span_data;
          word_nx  = {1'b0, span_x[8:2]};
          beat_nx  = 2'd0;
          state_nx = READ;
        end else begin
          state_nx = IDLE;
        end
      end
      READ: state_nx = MERGE;
      MERGE: begin
        if (beat == 2'd0) begin
          carry_nx = cmb_previous_out;
        end else begin
          carry_nx = carry;
        end
        if (!last) begin
          beat_nx  = beat + 2'd1;
          word_nx  = word + 8'd1;
          state_nx = READ;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    ready_nx  = (state_nx == IDLE);
    addr_nx   = (state_nx == IDLE) ? 7'd0 : word_nx[6:0];
    rd_nx     = (state_nx == READ);
    we_nx     = (state_nx == MERGE) && ({24'd0, word_nx} < LINE_WORDS);
    first_nx  = 1'b0;
    offset_nx = 2'd0;
    cz_nx     = 2'd0;
    cpal_nx   = 4'd0;
    tile_nx   = 32'd0;
    prev_nx   = 12'd0;
    done_nx   = 1'b0;
    if (state_nx == MERGE) begin
      first_nx  = (beat_nx == 2'd0);
      offset_nx = off_nx;
      cz_nx     = z_nx;
      cpal_nx   = pal_nx;
      // The third beat only flushes the nibbles carried out of the second word.
      tile_nx   = (beat_nx == 2'd2) ? 32'd0 : data_nx;
      prev_nx   = (beat_nx == 2'd0) ? 12'd0 : carry_nx;
      done_nx   = (beat_nx == ((off_nx == 2'd0) ? 2'd1 : 2'd2));
    end else begin
      first_nx  = 1'b0;
    end
  end

  // State and output registers; synchronous reset clears everything, including span_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat         <= 2'd0;
      word         <= 8'd0;
      off          <= 2'd0;
      z            <= 2'd0;
      pal          <= 4'd0;
      data         <= 32'd0;
      carry        <= 12'd0;
      span_ready   <= 1'b0;
      span_done    <= 1'b0;
      lb_addr      <= 7'd0;
      lb_rd        <= 1'b0;
      lb_we        <= 1'b0;
      cmb_first    <= 1'b0;
      cmb_offset   <= 2'd0;
      cmb_z        <= 2'd0;
      cmb_palette  <= 4'd0;
      cmb_tile     <= 32'd0;
      cmb_previous <= 12'd0;
    end else begin
      state        <= state_nx;
      beat         <= beat_nx;
      word         <= word_nx;
      off          <= off_nx;
      z            <= z_nx;
      pal          <= pal_nx;
      data         <= data_nx;
      carry        <= carry_nx;
      span_ready   <= ready_nx;
      span_done    <= done_nx;
      lb_addr      <= addr_nx;
      lb_rd        <= rd_nx;
      lb_we        <= we_nx;
      cmb_first    <= first_nx;
      cmb_offset   <= offset_nx;
      cmb_z        <= cz_nx;
      cmb_palette  <= cpal_nx;
      cmb_tile     <= tile_nx;
      cmb_previous <= prev_nx;
    end
  end

endmodule

// File: tb/tb_span_sequencer.sv
// Scoreboard bench for span_sequencer: every clock cycle's outputs are checked
// against per-cycle expectations generated from each accepted span.
module tb_span_sequencer;

  localparam int unsigned LW = 80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        span_valid;
  logic        span_ready;
  logic [8:0]  span_x;
  logic [1:0]  span_z;
  logic [3:0]  span_palette;
  logic [31:0] span_data;
  logic        span_done;
  logic [6:0]  lb_addr;
  logic        lb_rd, lb_we, cmb_first;
  logic [1:0]  cmb_offset, cmb_z;
  logic [3:0]  cmb_palette;
  logic [31:0] cmb_tile;
  logic [11:0] cmb_previous, cmb_previous_out;

  typedef struct packed {
    logic        ready;
    logic [6:0]  addr;
    logic        rd;
    logic        we;
    logic        first;
    logic [1:0]  offset;
    logic [1:0]  z;
    logic [3:0]  pal;
    logic [31:0] tile;
    logic [11:0] prev;
    logic        done;
  } obs_t;

  obs_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  span_sequencer #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n), .span_valid(span_valid), .span_ready(span_ready),
    .span_x(span_x), .span_z(span_z), .span_palette(span_palette), .span_data(span_data),
    .span_done(span_done), .lb_addr(lb_addr), .lb_rd(lb_rd), .lb_we(lb_we),
    .cmb_first(cmb_first), .cmb_offset(cmb_offset), .cmb_z(cmb_z),
    .cmb_palette(cmb_palette), .cmb_tile(cmb_tile), .cmb_previous(cmb_previous),
    .cmb_previous_out(cmb_previous_out)
  );

  // Stand-in combiner: reports the top three nibbles of the tile it is given.
  assign cmb_previous_out = cmb_tile[31:20];

  always #5 clk = ~clk;

  // Reference: a span covers words x/4 .. x/4+beats-1, one read cycle then one merge cycle each.
  task automatic push_span(input logic [8:0] x, input logic [1:0] zz,
                           input logic [3:0] pp, input logic [31:0] d);
    int   beats;
    int   w;
    obs_t e;
    beats = (x % 4 == 0) ? 2 : 3;
    for (int b = 0; b < beats; b++) begin
      w = int'(x / 4) + b;
      e = '0;
      e.addr = 7'(w % 128);
      e.rd = 1'b1;
      sb.push_back(e);
      e = '0;
      e.addr   = 7'(w % 128);
      e.we     = (w < LW);
      e.first  = (b == 0);
      e.offset = 2'(x % 4);
      e.z      = zz;
      e.pal    = pp;
      e.tile   = (b < 2) ? d : 32'd0;
      e.prev   = (b == 0) ? 12'd0 : d[31:20];
      e.done   = (b == beats - 1);
      sb.push_back(e);
    end
  endtask

  // Present a span and keep span_valid high until it is taken (bounded wait).
  task automatic issue_span(input logic [8:0] x, input logic [1:0] zz,
                            input logic [3:0] pp, input logic [31:0] d);
    int waited;
    bit taken;
    span_x = x; span_z = zz; span_palette = pp; span_data = d;
    span_valid = 1'b1;
    waited = 0;
    taken = 1'b0;
    while (!taken && waited < 20) begin
      @(negedge clk); #1;
      if (span_ready) begin
        push_span(x, zz, pp, d);
        taken = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    if (!taken) begin
      total++; bad++;
      $display("FAIL accept_timeout x=%0d actual=not_accepted required=accepted", x);
    end
  endtask

  // Monitor: compare every cycle's outputs with the next scoreboard entry (idle when empty).
  always @(negedge clk) begin
    obs_t act, exp_o;
    if (mon_en) begin
      act = {span_ready, lb_addr, lb_rd, lb_we, cmb_first, cmb_offset, cmb_z,
             cmb_palette, cmb_tile, cmb_previous, span_done};
      if (sb.size() > 0) begin
        exp_o = sb.pop_front();
      end else begin
        exp_o = '0;
        exp_o.ready = 1'b1;
      end
      total++;
      if (act !== exp_o) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, exp_o);
      end
    end
  end

  initial begin
    obs_t z0;
    int   n;
    z0 = '0;
    rst_n = 1'b0;
    span_valid = 1'b0;
    span_x = 9'd0; span_z = 2'd0; span_palette = 4'd0; span_data = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.push_back(z0);   // still-in-reset cycle: everything low, span_ready too
    mon_en = 1'b1;
    @(posedge clk); #1;

    issue_span(9'd8, 2'd1, 4'd3, 32'h12345678);
    span_valid = 1'b0;
    issue_span(9'd13, 2'd2, 4'd5, 32'h9ABCDEF0);
    span_valid = 1'b0;
    issue_span(9'd318, 2'd3, 4'd7, 32'h0F0F1234);
    // Held request over two spans.
    issue_span(9'd100, 2'd0, 4'd1, 32'h11112222);
    issue_span(9'd41, 2'd1, 4'd2, 32'h33334444);
    span_valid = 1'b0;
    repeat (8) @(posedge clk); #1;

    // Reset during the second merge beat of a three-beat span.
    issue_span(9'd13, 2'd2, 4'd9, 32'hCAFEF00D);
    span_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    sb.delete();
    sb.push_back(z0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      issue_span(9'($urandom_range(0, 511)), 2'($urandom), 4'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        span_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    span_valid = 1'b0;

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/span_sequencer.md
SPAN_SEQUENCER -- requirements
Module: span_sequencer

Interface
REQ-001 Parameter LINE_WORDS, default 80, number of 32-bit words (4 pixels each) in one line back buffer; word addresses >= LINE_WORDS are off-line.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 span_valid  input  1  span request present.
REQ-005 span_ready  output  1  block idle, accepts a span this cycle.
REQ-006 span_x  input  9  leftmost pixel x of 8-pixel tile row; word = x[8:2], offset = x[1:0].
REQ-007 span_z  input  2  layer priority of span.
REQ-008 span_palette  input  4  palette select of span.
REQ-009 span_data  input  32  tile row, eight 4-bit pixels, 0 = transparent.
REQ-010 span_done  output  1  one-cycle pulse on completion of a span.
REQ-011 lb_addr  output  7  line back buffer word address (read and write share it).
REQ-012 lb_rd  output  1  line buffer read strobe; data, updated and z flags are valid at the combiner one cycle later.
REQ-013 lb_we  output  1  write strobe; the combiner's merged data/updated/z are written at lb_addr.
REQ-014 cmb_first  output  1  combiner first-beat select.
REQ-015 cmb_offset  output  2  combiner pixel offset.
REQ-016 cmb_z  output  2  combiner line z.
REQ-017 cmb_palette  output  4  combiner palette.
REQ-018 cmb_tile  output  32  combiner tile data.
REQ-019 cmb_previous  output  12  carried nibbles H,G,F from the previous beat.
REQ-020 cmb_previous_out  input  12  combiner's nibbles H,G,F of the current tile data.

Function
REQ-021 FSM states IDLE, READ, MERGE; span_ready=1 only in IDLE.
REQ-022 IDLE with span_valid=1: latch x, z, palette and data; set word=x[8:2] and beat=0; go to READ.
REQ-023 READ: lb_addr=word, lb_rd=1, lb_we=0; go to MERGE next cycle.
REQ-024 MERGE: lb_addr=word, lb_rd=0; drive the cmb_* outputs from the latched span; lb_we=1 only if word < LINE_WORDS.
REQ-025 Beat count: 2 when offset=0, 3 when offset!=0; beat b targets word x[8:2]+b.
REQ-026 cmb_first=1 on beat 0 only; cmb_offset=latched offset on all beats.
REQ-027 cmb_tile=latched data on beats 0,1; 0 on beat 2 (only carried nibbles contribute).
REQ-028 cmb_previous=0 on beat 0; on beats 1,2 it equals the register loaded from cmb_previous_out in the beat-0 MERGE cycle.
REQ-029 In MERGE, if the beat is not last: beat+1, word+1, go to READ; if last: span_done=1 this cycle, go to IDLE.
REQ-030 Word increment computed in 8 bits; no wrap to 0 -- off-line words are read but never written (clipping).
REQ-031 Outside MERGE, all cmb_* outputs = 0; in IDLE, lb_addr=0, lb_rd=0, lb_we=0.
REQ-032 Span latency: 2*beats cycles from the accept cycle to the span_done cycle inclusive of MERGE (4 or 6); the next span is acceptable the cycle after span_done.
REQ-033 span_valid is ignored outside IDLE; a request held across a busy period is accepted at the next IDLE.

Reset
REQ-034 rst_n=0 at a clock edge: state IDLE, beat=0, word=0, carried register=0, every output 0 including span_ready.
REQ-035 span_ready returns to 1 in the first cycle after rst_n=1.
REQ-036 Reset mid-span abandons it: no further lb_we and no span_done for that span.

Verification
REQ-037 x=8, data=0x12345678, offset 0 -> READ/MERGE at addr 2 (first=1), then addr 3 (first=0, previous=0x123); span_done in the 4th cycle after accept; 2 writes.
REQ-038 x=13 -> addr 3,4,5 with offset 1; beat 2 has cmb_tile=0 and cmb_previous equal to the beat-0 cmb_previous_out; 3 writes; span_done on cycle 6.
REQ-039 LINE_WORDS=80, x=318 -> word 79 written; words 80,81 strobe lb_rd but lb_we stays 0; span_done still pulses.
REQ-040 span_valid held high over two spans -> span_ready=0 while busy; second span accepted the cycle after the first span_done; no lost or duplicated span.
REQ-041 rst_n=0 during MERGE of beat 1 -> next cycle all outputs 0, no span_done; span_ready=1 one cycle after rst_n=1.
